// File: rtl/uart_tcp_host_bridge.sv
// uart_tcp_host_bridge
//   Host-side peer of the chip's UART command mux. Turns typed host commands
//   into header/[addr]/data bytes on the UART TX stream. Turns header+data
//   byte pairs from the UART RX stream into typed responses.
//   Optional feature macro: UART_HOST_RX_TIMEOUT_EN. When it is defined, a
//   missing response data byte is abandoned after TIMEOUT_CYCLES cycles.
//
//   TX FSM
//   state   | meaning
//   TX_IDLE | ready for a host command
//   TX_HDR  | sending header byte {5'b0,type}
//   TX_ADDR | sending INFO field index
//   TX_DATA | sending payload byte
//
//   RX FSM
//   state   | meaning
//   RX_HDR  | waiting for a response header byte
//   RX_DATA | waiting for the data byte that goes with the header
//   RX_HOLD | response presented, waiting for the host to take it
module uart_tcp_host_bridge #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_tvalid,
  output logic       cmd_tready,
  input  logic [2:0] cmd_type,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_tdata,
  output logic       cmd_err,
  output logic       uart_tx_tvalid,
  input  logic       uart_tx_tready,
  output logic [7:0] uart_tx_tdata,
  input  logic       uart_rx_tvalid,
  output logic       uart_rx_tready,
  input  logic [7:0] uart_rx_tdata,
  output logic       resp_tvalid,
  input  logic       resp_tready,
  output logic [2:0] resp_type,
  output logic [7:0] resp_tdata,
  output logic       hdr_err,
  output logic       rx_timeout
);

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_ADDR, TX_DATA} tx_state_t;
  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_HOLD} rx_state_t;

  localparam logic [2:0] T_PARROT = 3'd0;
  localparam logic [2:0] T_INFO   = 3'd7;

  // Command types the chip understands: PARROT, ETH_FRAME_IN, INSTRUCTION,
  // PAYLOAD_COMING, INFO.
  function automatic logic cmd_type_ok(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd4) || (t == 3'd6) || (t == 3'd7);
  endfunction

  // Response headers the chip can send: PARROT, ETH_FRAME_OUT,
  // REMAINING_LAYER, BRAIN_STATUS. Any upper bit set is unknown.
  function automatic logic rsp_hdr_ok(input logic [7:0] h);
    return (h == 8'd0) || (h == 8'd2) || (h == 8'd3) || (h == 8'd5);
  endfunction

  tx_state_t  tx_state, tx_next;
  logic [2:0] type_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       cmd_hs;
  logic       tx_hs;

  rx_state_t  rx_state, rx_next;
  logic [7:0] hdr_q;
  logic [2:0] resp_type_q;
  logic [7:0] resp_data_q;
  logic       rx_hs;
  logic       to_hit;

  assign cmd_tready     = !rst && (tx_state == TX_IDLE);
  assign cmd_hs         = cmd_tvalid && cmd_tready;
  assign cmd_err        = cmd_hs && !cmd_type_ok(cmd_type);
  assign uart_tx_tvalid = !rst && (tx_state != TX_IDLE);
  assign tx_hs          = uart_tx_tvalid && uart_tx_tready;

  // TX next state and byte mux; each byte advances only on its handshake.
  always_comb begin
    tx_next       = tx_state;
    uart_tx_tdata = 8'h00;
    case (tx_state)
      TX_IDLE: begin
        if (cmd_hs && cmd_type_ok(cmd_type)) tx_next = TX_HDR;
      end
      TX_HDR: begin
        uart_tx_tdata = {5'b0, type_q};
        if (tx_hs) begin
          if (type_q == T_PARROT)    tx_next = TX_IDLE;
          else if (type_q == T_INFO) tx_next = TX_ADDR;
          else                       tx_next = TX_DATA;
        end
      end
      TX_ADDR: begin
        uart_tx_tdata = addr_q;
        if (tx_hs) tx_next = TX_DATA;
      end
      TX_DATA: begin
        uart_tx_tdata = data_q;
        if (tx_hs) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
    if (rst) uart_tx_tdata = 8'h00;
  end

  // TX state register and command capture on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      type_q   <= 3'd0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      tx_state <= tx_next;
      if (cmd_hs) begin
        type_q <= cmd_type;
        addr_q <= cmd_addr;
        data_q <= cmd_tdata;
      end
    end
  end

  assign uart_rx_tready = !rst && ((rx_state == RX_HDR) || (rx_state == RX_DATA));
  assign rx_hs          = uart_rx_tvalid && uart_rx_tready;
  assign resp_tvalid    = !rst && (rx_state == RX_HOLD);
  assign resp_type      = rst ? 3'd0 : resp_type_q;
  assign resp_tdata     = rst ? 8'h00 : resp_data_q;
  assign hdr_err        = rx_hs && (rx_state == RX_DATA) && !rsp_hdr_ok(hdr_q);
  assign rx_timeout     = !rst && to_hit;

`ifdef UART_HOST_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // A byte landing on the terminal cycle wins over the timeout.
  assign to_hit = (rx_state == RX_DATA) && !rx_hs &&
                  (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: zero outside RX_DATA, counts idle RX_DATA cycles.
  always_ff @(posedge clk) begin
    if (rst || (rx_state != RX_DATA)) to_cnt <= '0;
    else if (!rx_hs)                  to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // RX next state: header, data, then hold the response until taken.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_HDR: begin
        if (rx_hs) rx_next = RX_DATA;
      end
      RX_DATA: begin
        if (rx_hs)       rx_next = rsp_hdr_ok(hdr_q) ? RX_HOLD : RX_HDR;
        else if (to_hit) rx_next = RX_HDR;
      end
      RX_HOLD: begin
        if (resp_tready) rx_next = RX_HDR;
      end
      default: rx_next = RX_HDR;
    endcase
  end

  // RX state register, header capture and response load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_HDR;
      hdr_q       <= 8'h00;
      resp_type_q <= 3'd0;
      resp_data_q <= 8'h00;
    end else begin
      rx_state <= rx_next;
      if (rx_hs && (rx_state == RX_HDR)) hdr_q <= uart_rx_tdata;
      if (rx_hs && (rx_state == RX_DATA) && rsp_hdr_ok(hdr_q)) begin
        resp_type_q <= hdr_q[2:0];
        resp_data_q <= uart_rx_tdata;
      end
    end
  end

endmodule

// File: tb/tb_uart_tcp_host_bridge.sv
// Directed bench for uart_tcp_host_bridge. Inputs change 1ns after posedge,
// outputs are observed on negedge.
module tb_uart_tcp_host_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_tvalid, cmd_tready;
  logic [2:0] cmd_type;
  logic [7:0] cmd_addr, cmd_tdata;
  logic       cmd_err;
  logic       uart_tx_tvalid, uart_tx_tready;
  logic [7:0] uart_tx_tdata;
  logic       uart_rx_tvalid, uart_rx_tready;
  logic [7:0] uart_rx_tdata;
  logic       resp_tvalid, resp_tready;
  logic [2:0] resp_type;
  logic [7:0] resp_tdata;
  logic       hdr_err, rx_timeout;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_q[$];
  logic [10:0] resp_q[$];
  int tx_viol = 0, resp_viol = 0;
  int cmd_err_n = 0, hdr_err_n = 0, timeout_n = 0;
  logic       tx_stall_p = 1'b0, resp_stall_p = 1'b0;
  logic [7:0] tx_data_p = 8'h00;
  logic [10:0] resp_p = '0;

  always #5 clk = ~clk;

  uart_tcp_host_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_tdata(cmd_tdata), .cmd_err(cmd_err),
    .uart_tx_tvalid(uart_tx_tvalid), .uart_tx_tready(uart_tx_tready),
    .uart_tx_tdata(uart_tx_tdata),
    .uart_rx_tvalid(uart_rx_tvalid), .uart_rx_tready(uart_rx_tready),
    .uart_rx_tdata(uart_rx_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_type(resp_type),
    .resp_tdata(resp_tdata), .hdr_err(hdr_err), .rx_timeout(rx_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Negedge monitor: logs handshaken bytes/responses, pulses, stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_stall_p && (!uart_tx_tvalid || uart_tx_tdata != tx_data_p)) tx_viol++;
      if (resp_stall_p && (!resp_tvalid || {resp_type, resp_tdata} != resp_p)) resp_viol++;
      if (uart_tx_tvalid && uart_tx_tready) tx_q.push_back(uart_tx_tdata);
      if (resp_tvalid && resp_tready) resp_q.push_back({resp_type, resp_tdata});
      if (cmd_err) cmd_err_n++;
      if (hdr_err) hdr_err_n++;
      if (rx_timeout) timeout_n++;
    end
    tx_stall_p   = !rst && uart_tx_tvalid && !uart_tx_tready;
    tx_data_p    = uart_tx_tdata;
    resp_stall_p = !rst && resp_tvalid && !resp_tready;
    resp_p       = {resp_type, resp_tdata};
  end

  task automatic send_cmd(input logic [2:0] t, input logic [7:0] a, input logic [7:0] d);
    logic ok = 1'b0;
    cmd_tvalid = 1'b1; cmd_type = t; cmd_addr = a; cmd_tdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_tready;
    end
    chk("cmd_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    cmd_tvalid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    logic ok = 1'b0;
    uart_rx_tvalid = 1'b1; uart_rx_tdata = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = uart_rx_tready;
    end
    chk("rx_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    uart_rx_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic flag;
    rst = 1'b1; cmd_tvalid = 0; cmd_type = 0; cmd_addr = 0; cmd_tdata = 0;
    uart_tx_tready = 1; uart_rx_tvalid = 0; uart_rx_tdata = 0; resp_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {6'd0, cmd_tready, cmd_err, uart_tx_tvalid, uart_tx_tdata,
                       uart_rx_tready, resp_tvalid, resp_type, resp_tdata, hdr_err,
                       rx_timeout}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {30'd0, cmd_tready, uart_rx_tready}, 32'd3);
    @(posedge clk); #1;

    // 1: INSTRUCTION, two bytes back to back, ready again right after
    send_cmd(3'd4, 8'h00, 8'hA5);
    @(negedge clk);
    chk("t1_hdr", {22'd0, uart_tx_tvalid, cmd_tready, uart_tx_tdata}, {22'd0, 2'b10, 8'h04});
    @(negedge clk);
    chk("t1_data", {22'd0, uart_tx_tvalid, cmd_tready, uart_tx_tdata}, {22'd0, 2'b10, 8'hA5});
    @(negedge clk);
    chk("t1_ready", {30'd0, uart_tx_tvalid, cmd_tready}, 32'd1);
    idle(2);
    chk("t1_count", tx_q.size(), 2);
    tx_q.delete();

    // 2: INFO under toggling ready, then PARROT
    fork
      repeat (24) begin @(posedge clk); #1 uart_tx_tready = ~uart_tx_tready; end
    join_none
    send_cmd(3'd7, 8'h0C, 8'hC0);
    idle(26);
    uart_tx_tready = 1'b1;
    chk("t2_count", tx_q.size(), 3);
    if (tx_q.size() == 3) begin
      chk("t2_b0", tx_q[0], 8'h07);
      chk("t2_b1", tx_q[1], 8'h0C);
      chk("t2_b2", tx_q[2], 8'hC0);
    end
    chk("t2_stable", tx_viol, 0);
    tx_q.delete();
    send_cmd(3'd0, 8'h33, 8'h44);
    idle(4);
    chk("t2_parrot_n", tx_q.size(), 1);
    if (tx_q.size() == 1) chk("t2_parrot", tx_q[0], 8'h00);
    tx_q.delete();

    // 3: invalid command type and unknown response header
    send_cmd(3'd3, 8'h00, 8'h99);
    idle(4);
    chk("t3_cmd_err", cmd_err_n, 1);
    chk("t3_no_tx", tx_q.size(), 0);
    rx_byte(8'h09);
    rx_byte(8'h55);
    idle(3);
    chk("t3_hdr_err", hdr_err_n, 1);
    chk("t3_no_resp", resp_q.size(), 0);

    // 4: response held under back-pressure
    resp_tready = 1'b0;
    rx_byte(8'h03);
    rx_byte(8'h11);
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!resp_tvalid || resp_type != 3'd3 || resp_tdata != 8'h11 || uart_rx_tready) flag = 1'b0;
    end
    chk("t4_held", {31'd0, flag}, 32'd1);
    @(posedge clk); #1 resp_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_rx_ready", {30'd0, resp_tvalid, uart_rx_tready}, 32'd1);
    chk("t4_count", resp_q.size(), 1);
    if (resp_q.size() == 1) chk("t4_resp", resp_q[0], {3'd3, 8'h11});
    chk("t4_stable", resp_viol, 0);
    resp_q.delete();
    @(posedge clk); #1;

    // 5: two responses back to back
    rx_byte(8'h02); rx_byte(8'hEE);
    rx_byte(8'h05); rx_byte(8'h01);
    idle(4);
    chk("t5_count", resp_q.size(), 2);
    if (resp_q.size() == 2) begin
      chk("t5_r0", resp_q[0], {3'd2, 8'hEE});
      chk("t5_r1", resp_q[1], {3'd5, 8'h01});
    end
    resp_q.delete();

    // Reset mid-frame: stalled INFO is abandoned, next command starts clean
    uart_tx_tready = 1'b0;
    send_cmd(3'd7, 8'h01, 8'h02);
    idle(2);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_mid", {30'd0, uart_tx_tvalid, cmd_tready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; uart_tx_tready = 1'b1;
    tx_q.delete();
    send_cmd(3'd1, 8'h00, 8'h3C);
    idle(4);
    chk("rst_next_n", tx_q.size(), 2);
    if (tx_q.size() == 2) chk("rst_next", {tx_q[0], tx_q[1]}, 16'h013C);
    tx_q.delete();

`ifdef UART_HOST_RX_TIMEOUT_EN
    // 6: header then silence -> timeout on the 16th RX_DATA cycle
    rx_byte(8'h05);
    flag = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16 && rx_timeout) flag = 1'b0;
      if (k == 16) chk("t6_timeout_at16", {31'd0, rx_timeout}, 32'd1);
    end
    chk("t6_not_early", {31'd0, flag}, 32'd1);
    @(posedge clk); #1;
    rx_byte(8'h00); rx_byte(8'h00);
    idle(3);
    chk("t6_timeouts", timeout_n, 1);
    chk("t6_count", resp_q.size(), 1);
    if (resp_q.size() == 1) chk("t6_resp", resp_q[0], 11'd0);
`else
    // Without the timeout, RX_DATA simply waits for the late byte
    rx_byte(8'h05);
    idle(40);
    rx_byte(8'h01);
    idle(3);
    chk("wait_no_timeout", timeout_n, 0);
    chk("wait_count", resp_q.size(), 1);
    if (resp_q.size() == 1) chk("wait_resp", resp_q[0], {3'd5, 8'h01});
`endif
    resp_q.delete();
    chk("final_hdr_err", hdr_err_n, 1);
    chk("final_cmd_err", cmd_err_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
